// File: rtl/step_pulse_gen.sv
// Per-axis step/dir pulse generator: integrates signed velocity into a fractional step phase,
// queues whole steps in a small signed pending counter and emits timed STEP/DIR pulses.
module step_pulse_gen #(
  parameter int STEP_HIGH = 2,
  parameter int STEP_LOW  = 2,
  parameter int DIR_SETUP = 4,
  parameter int PEND_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] velocity,
  input  logic        load_position,
  input  logic [31:0] new_position,
  input  logic        clear_fault,
  output logic        step,
  output logic        dir,
  output logic [31:0] position,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam logic [15:0] HIGH_RELOAD  = 16'(STEP_HIGH - 1);
  localparam logic [15:0] LOW_RELOAD   = 16'(STEP_LOW - 1);
  localparam logic [15:0] SETUP_RELOAD = 16'(DIR_SETUP - 1);
  localparam int          EW           = PEND_W + 2;
  localparam int          PMAX         = (2 ** (PEND_W - 1)) - 1;
  localparam logic signed [EW-1:0] PMAX_E = EW'(PMAX);
  localparam logic signed [EW-1:0] NMAX_E = EW'(-PMAX);

  state_t              state, state_next;
  logic [15:0]         cnt, cnt_next;
  logic [30:0]         phase, phase_next;
  logic [PEND_W-1:0]   pending, pending_next;
  logic                step_next, dir_next, busy_next, overflow_next;
  logic [31:0]         position_next;

  // ---------------- integrator ----------------
  logic signed [31:0] v_sat;
  logic signed [33:0] sum;
  logic               req_pos, req_neg;

  always_comb begin
    v_sat = (velocity == 32'h8000_0000) ? 32'sh8000_0001 : $signed(velocity);
    sum   = $signed({3'b000, phase}) + $signed({{2{v_sat[31]}}, v_sat});
    // The wrapped phase is always the low 31 bits of sum, whichever way it crossed.
    req_pos    = enable && !sum[33] && (sum[32] || sum[31]);
    req_neg    = enable && sum[33];
    phase_next = enable ? sum[30:0] : phase;
  end

  // ---------------- pending counter ----------------
  logic                 desired, pend_nz, issue;
  logic signed [EW-1:0] pend_ext, req_v, iss_v, sum_all, pend_sum;
  logic                 ovf_hit;

  assign desired = pending[PEND_W-1];
  assign pend_nz = |pending;

  always_comb begin
    pend_ext = {{2{pending[PEND_W-1]}}, pending};
    req_v    = '0;
    if (req_pos) req_v = {{(EW-1){1'b0}}, 1'b1};
    if (req_neg) req_v = '1;
    iss_v    = '0;
    if (issue) iss_v = dir ? '1 : {{(EW-1){1'b0}}, 1'b1};
    sum_all  = pend_ext + req_v - iss_v;
    // A request that would push the counter past capacity is dropped; the issue still counts.
    ovf_hit  = (sum_all > PMAX_E) || (sum_all < NMAX_E);
    pend_sum = ovf_hit ? (pend_ext - iss_v) : sum_all;
    pending_next = pend_sum[PEND_W-1:0];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= '0;
      pending  <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      position <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      phase    <= phase_next;
      pending  <= pending_next;
      step     <= step_next;
      dir      <= dir_next;
      position <= position_next;
      busy     <= busy_next;
      overflow <= overflow_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_nz) begin
          if (desired == dir) begin
            issue      = 1'b1;
            cnt_next   = HIGH_RELOAD;
            state_next = HIGH;
          end else begin
            cnt_next   = SETUP_RELOAD;
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt != 16'd0) begin
          cnt_next = cnt - 16'd1;
        end else if (pend_nz && (desired == dir)) begin
          issue      = 1'b1;
          cnt_next   = HIGH_RELOAD;
          state_next = HIGH;
        end else begin
          // Pending drained or flipped while DIR settled: re-evaluate from IDLE.
          state_next = IDLE;
        end
      end
      HIGH: begin
        if (cnt != 16'd0) begin
          cnt_next = cnt - 16'd1;
        end else begin
          cnt_next   = LOW_RELOAD;
          state_next = LOW;
        end
      end
      LOW: begin
        if (cnt != 16'd0) cnt_next = cnt - 16'd1;
        else              state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    dir_next = dir;
    if (state == IDLE && pend_nz && desired != dir) dir_next = desired;

    step_next = step;
    if (issue)                                  step_next = 1'b1;
    else if (state == HIGH && cnt == 16'd0)     step_next = 1'b0;

    // load_position wins over a coincident step-rise update.
    position_next = position;
    if (load_position)  position_next = new_position;
    else if (issue)     position_next = dir ? (position - 32'd1) : (position + 32'd1);

    busy_next     = (pending_next != '0) || (state_next != IDLE);
    overflow_next = ovf_hit ? 1'b1 : (clear_fault ? 1'b0 : overflow);
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: hand-computed pulse counts, positions, timing gaps and
// overflow behaviour, with a negedge pulse monitor feeding the checks.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        reset, enable, load_position, clear_fault;
  logic [31:0] velocity, new_position;
  logic        step, dir, busy, overflow;
  logic [31:0] position;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_pulse_gen dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .velocity      (velocity),
    .load_position (load_position),
    .new_position  (new_position),
    .clear_fault   (clear_fault),
    .step          (step),
    .dir           (dir),
    .position      (position),
    .busy          (busy),
    .overflow      (overflow)
  );

  // ---------------- pulse monitor ----------------
  int   n_rise, last_rise, min_period, high_len, min_high, max_high;
  int   last_fall, dir_chg_cyc, setup_gap, dir_gap;
  logic have_fall, setup_armed, prev_step, prev_dir;

  always @(negedge clk) begin
    if (reset) begin
      n_rise = 0; last_rise = 0; min_period = 1000; high_len = 0;
      min_high = 1000; max_high = 0; last_fall = 0; dir_chg_cyc = 0;
      setup_gap = 0; dir_gap = 1000; have_fall = 1'b0; setup_armed = 1'b0;
    end else begin
      if (dir !== prev_dir) begin
        dir_chg_cyc = cyc;
        setup_armed = 1'b1;
        dir_gap     = have_fall ? (cyc - last_fall) : 1000;
      end
      if (step && !prev_step) begin
        if (n_rise > 0 && (cyc - last_rise) < min_period) min_period = cyc - last_rise;
        last_rise = cyc;
        n_rise++;
        high_len = 1;
        if (setup_armed) begin
          setup_gap   = cyc - dir_chg_cyc;
          setup_armed = 1'b0;
        end
      end else if (step && prev_step) begin
        high_len++;
      end
      if (!step && prev_step) begin
        if (high_len < min_high) min_high = high_len;
        if (high_len > max_high) max_high = high_len;
        last_fall = cyc;
        have_fall = 1'b1;
      end
    end
    prev_step = step;
    prev_dir  = dir;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Leaves reset asserted; the caller releases it together with the first stimulus.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; velocity = '0; load_position = 1'b0;
    new_position = '0; clear_fault = 1'b0;
    ticks(2);
  endtask

  task automatic start(input logic [31:0] vel);
    base     = cyc;
    reset    = 1'b0;
    velocity = vel;
    enable   = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while ((busy || step) && k < max) begin
      tick();
      k++;
    end
    check_eq({tag, "_drained"}, {30'd0, busy, step}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1: +1/8 step per clock for 80 clocks -> 10 positive pulses
    do_reset();
    check_eq("rst_step", {31'd0, step}, 32'd0);
    check_eq("rst_dir", {31'd0, dir}, 32'd0);
    check_eq("rst_position", position, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    start(32'h1000_0000);
    ticks(80);
    enable = 1'b0;
    wait_idle("t1", 300);
    check_eq("t1_pulses", n_rise, 10);
    check_eq("t1_position", position, 32'd10);
    check_eq("t1_dir", {31'd0, dir}, 32'd0);
    check_eq("t1_min_high", min_high, 2);
    check_eq("t1_max_high", max_high, 2);
    check_eq("t1_overflow", {31'd0, overflow}, 32'd0);
    check_eq("t1_busy", {31'd0, busy}, 32'd0);

    // 2: -1/8 step per clock -> DIR flips on edge 2, first rise 4 clocks later
    do_reset();
    start(32'hF000_0000);
    ticks(80);
    enable = 1'b0;
    wait_idle("t2", 300);
    check_eq("t2_dir_edge", dir_chg_cyc - base, 2);
    check_eq("t2_setup_gap", setup_gap, 4);
    check_eq("t2_pulses", n_rise, 10);
    check_eq("t2_position", position, 32'hFFFF_FFF6);
    check_eq("t2_dir", {31'd0, dir}, 32'd1);

    // 3: 0.5 step per clock saturates pending at +7; 27 requests accepted overall
    do_reset();
    start(32'h4000_0000);
    ticks(100);
    check_eq("t3_overflow_set", {31'd0, overflow}, 32'd1);
    check_eq("t3_busy", {31'd0, busy}, 32'd1);
    check_eq("t3_pulses_100", n_rise, 20);
    check_eq("t3_position_100", position, 32'd20);
    check_eq("t3_min_period", min_period, 5);
    velocity = '0;
    wait_idle("t3", 300);
    check_eq("t3_pulses", n_rise, 27);
    check_eq("t3_position", position, 32'd27);
    check_eq("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_eq("t3_overflow_clear", {31'd0, overflow}, 32'd0);

    // 4: reversal while busy; +1 at edge 6 cancelled by -1 at edge 7
    do_reset();
    start(32'h4000_0000);
    ticks(6);
    velocity = 32'hE000_0000;
    ticks(8);
    enable = 1'b0;
    wait_idle("t4", 300);
    check_eq("t4_pulses", n_rise, 3);
    check_eq("t4_position", position, 32'd1);
    check_eq("t4_dir", {31'd0, dir}, 32'd1);
    check_eq("t4_dir_edge", dir_chg_cyc - base, 13);
    check_eq("t4_dir_gap", dir_gap, 3);
    check_eq("t4_setup_gap", setup_gap, 4);

    // 5: most negative velocity -> one -1 request per clock; load coincident with a rise
    do_reset();
    start(32'h8000_0000);
    ticks(8);
    check_eq("t5_overflow_e8", {31'd0, overflow}, 32'd0);
    check_eq("t5_position_e8", position, 32'hFFFF_FFFF);
    check_eq("t5_dir", {31'd0, dir}, 32'd1);
    tick();
    check_eq("t5_overflow_e9", {31'd0, overflow}, 32'd1);
    tick();
    enable        = 1'b0;
    load_position = 1'b1;
    new_position  = 32'd1000;
    tick();
    load_position = 1'b0;
    check_eq("t5_load_position", position, 32'd1000);
    check_eq("t5_load_step", {31'd0, step}, 32'd1);
    wait_idle("t5", 300);
    check_eq("t5_position", position, 32'd994);
    check_eq("t5_pulses", n_rise, 8);

    // 6: reset while STEP is high
    do_reset();
    start(32'hC000_0000);
    ticks(6);
    check_eq("t6_step_high", {31'd0, step}, 32'd1);
    check_eq("t6_position_pre", position, 32'hFFFF_FFFF);
    reset = 1'b1;
    tick();
    check_eq("t6_step", {31'd0, step}, 32'd0);
    check_eq("t6_dir", {31'd0, dir}, 32'd0);
    check_eq("t6_position", position, 32'd0);
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    reset    = 1'b0;
    velocity = '0;
    enable   = 1'b0;
    ticks(30);
    check_eq("t6_no_pulse", n_rise, 0);
    check_eq("t6_busy_after", {31'd0, busy}, 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
